aes_key_schedule: RTL and testbench

- Parametrised successor of the AES-128 round-key generator.
- Supports AES-128, AES-192 and AES-256. Expands the cipher key once into an on-chip round-key store of up to 60 words.
- Serves any round key by index, so cipher and inverse-cipher cores can read keys in forward or reverse order.
- Sits between the key-load interface and the round datapath. Replaces per-round on-the-fly expansion.

---
 rtl/aes_key_schedule.sv | 247 ++++++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// -----------------------------------------------------------------------------
// aes_key_schedule
//
// Purpose:
//   Expands an AES-128/192/256 cipher key once into an on-chip round-key
//   store of 4*(MAX_NK+7) words, one word per clock, and serves any round key
//   by index so forward and inverse cipher cores can read keys in any order.
//
// Parameters:
//   MAX_NK      largest supported key length in 32-bit words (4, 6 or 8)
//
// Ports:
//   clk_sys     in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   key_valid   in   new key / key_len presented
//   key_ready   out  block can accept a key (IDLE or READY)
//   key_len     in   00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
//   cipher_key  in   key, MSB-aligned (w0 in the top 32 bits)
//   busy        out  expansion in progress
//   keys_valid  out  store holds a complete schedule for the last key
//   num_rounds  out  Nr of the stored schedule (0 after reset)
//   rk_rd_idx   in   round-key index 0..Nr
//   rk_rd_data  out  round key {w[4i],w[4i+1],w[4i+2],w[4i+3]}, combinational
//   cfg_err     out  one-cycle pulse after an unsupported key_len handshake
//   zeroize     in   (only with AES_KS_ZEROIZE_EN) clear store and abort
//
// Optional feature macro: AES_KS_ZEROIZE_EN
// -----------------------------------------------------------------------------
module aes_key_schedule #(
    parameter int unsigned MAX_NK = 8
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  cipher_key,
    output logic                  busy,
    output logic                  keys_valid,
    output logic [3:0]            num_rounds,
    input  logic [3:0]            rk_rd_idx,
    output logic [127:0]          rk_rd_data,
    output logic                  cfg_err
`ifdef AES_KS_ZEROIZE_EN
    ,
    input  logic                  zeroize
`endif
);

    localparam int unsigned DEPTH  = 4 * (MAX_NK + 7);
    localparam int unsigned IW     = $clog2(DEPTH);
    localparam int unsigned MAX_NR = MAX_NK + 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // GF(2^8) helpers; the S-box is the multiplicative inverse followed by the
    // AES affine transform, so no 256-entry table is needed.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = product of a^(2^k), k=1..7; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int unsigned k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t        state_q;
    logic          key_ready_q;
    logic          busy_q;
    logic          keys_valid_q;
    logic [3:0]    num_rounds_q;
    logic          cfg_err_q;
    logic [IW-1:0] nk_q;
    logic [IW-1:0] idx_q;     // index of the word written on the next edge
    logic [IW-1:0] last_q;    // 4*Nr+3
    logic [2:0]    mod_q;     // idx_q mod Nk
    logic [7:0]    rcon_q;
    logic [31:0]   w_q [DEPTH];

    logic          zero_w;
`ifdef AES_KS_ZEROIZE_EN
    assign zero_w = zeroize;
`else
    assign zero_w = 1'b0;
`endif

    // key_len decode
    logic [3:0] nk_new;
    logic       len_legal;
    always_comb begin
        case (key_len)
            2'b00:   nk_new = 4'd4;
            2'b01:   nk_new = 4'd6;
            2'b10:   nk_new = 4'd8;
            default: nk_new = 4'd0;
        endcase
        len_legal = (key_len != 2'b11) && (32'(nk_new) <= MAX_NK);
    end

    // Next expanded word
    logic [31:0] prev_w;
    logic [31:0] temp_w;
    logic [31:0] new_w;
    always_comb begin
        prev_w = w_q[idx_q - IW'(1)];
        temp_w = prev_w;
        if (mod_q == 3'd0) begin
            temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
        end else if (nk_q == IW'(8) && mod_q == 3'd4) begin
            temp_w = sub_word(prev_w);
        end
        new_w = w_q[idx_q - nk_q] ^ temp_w;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            num_rounds_q <= '0;
            cfg_err_q    <= 1'b0;
            nk_q         <= '0;
            idx_q        <= '0;
            last_q       <= '0;
            mod_q        <= '0;
            rcon_q       <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) w_q[j] <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            if (zero_w) begin
                state_q      <= IDLE;
                key_ready_q  <= 1'b1;
                busy_q       <= 1'b0;
                keys_valid_q <= 1'b0;
                num_rounds_q <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) w_q[j] <= '0;
            end else begin
                case (state_q)
                    IDLE, READY: begin
                        if (key_valid) begin
                            if (len_legal) begin
                                // Clear everything, then load the key words;
                                // later assignments win, so stale words from
                                // a longer previous key end up zero.
                                for (int unsigned j = 0; j < DEPTH; j++) w_q[j] <= '0;
                                for (int unsigned j = 0; j < MAX_NK; j++) begin
                                    if (j < 32'(nk_new))
                                        w_q[j] <= cipher_key[32*(MAX_NK-j)-1 -: 32];
                                end
                                nk_q         <= IW'(nk_new);
                                idx_q        <= IW'(nk_new);
                                last_q       <= IW'(32'(nk_new) * 4 + 27);
                                mod_q        <= '0;
                                rcon_q       <= 8'h01;
                                num_rounds_q <= nk_new + 4'd6;
                                keys_valid_q <= 1'b0;
                                busy_q       <= 1'b1;
                                key_ready_q  <= 1'b0;
                                state_q      <= EXPAND;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    EXPAND: begin
                        w_q[idx_q] <= new_w;
                        idx_q      <= idx_q + IW'(1);
                        mod_q      <= (IW'(mod_q) == nk_q - IW'(1)) ? 3'd0 : mod_q + 3'd1;
                        if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
                        if (idx_q == last_q) begin
                            state_q      <= READY;
                            busy_q       <= 1'b0;
                            keys_valid_q <= 1'b1;
                            key_ready_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        key_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read mux over constant indices only; anything above num_rounds or the
    // largest supported Nr reads as zero.
    always_comb begin
        rk_rd_data = '0;
        for (int unsigned r = 0; r <= MAX_NR; r++) begin
            if (rk_rd_idx == 4'(r) && 4'(r) <= num_rounds_q)
                rk_rd_data = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
        end
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;
    assign num_rounds = num_rounds_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_aes_key_schedule
//
// Directed test of aes_key_schedule with FIPS-197 key-expansion vectors:
// AES-128/192/256 schedules and latencies, reserved key_len, reload from
// READY, key_valid held during expansion, a MAX_NK=4 instance rejecting
// AES-256, reset mid-expansion and (with AES_KS_ZEROIZE_EN) zeroize.
// -----------------------------------------------------------------------------
module tb_aes_key_schedule;

    localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk_sys = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [1:0]   key_len;
    logic [255:0] cipher_key;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   num_rounds;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         cfg_err;
    logic         zeroize;

    logic         kv4;
    logic         kr4;
    logic [1:0]   kl4;
    logic [127:0] ck4;
    logic         busy4;
    logic         kvalid4;
    logic [3:0]   nr4;
    logic [3:0]   idx4;
    logic [127:0] data4;
    logic         cerr4;
    logic         zero4;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_sys = ~clk_sys;

    aes_key_schedule #(.MAX_NK(8)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_len    (key_len),
        .cipher_key (cipher_key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .num_rounds (num_rounds),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .cfg_err    (cfg_err)
`ifdef AES_KS_ZEROIZE_EN
        ,
        .zeroize    (zeroize)
`endif
    );

    aes_key_schedule #(.MAX_NK(4)) dut4 (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .key_valid  (kv4),
        .key_ready  (kr4),
        .key_len    (kl4),
        .cipher_key (ck4),
        .busy       (busy4),
        .keys_valid (kvalid4),
        .num_rounds (nr4),
        .rk_rd_idx  (idx4),
        .rk_rd_data (data4),
        .cfg_err    (cerr4)
`ifdef AES_KS_ZEROIZE_EN
        ,
        .zeroize    (zero4)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        rk_rd_idx = idx;
        #1;
        chk(tag, rk_rd_data, exp);
    endtask

    // Present one key for exactly one rising edge; returns #1 after that edge.
    task automatic accept(input logic [1:0] len, input logic [255:0] key);
        @(negedge clk_sys);
        key_valid  = 1'b1;
        key_len    = len;
        cipher_key = key;
        @(posedge clk_sys);
        #1;
        key_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_len = 2'b00; cipher_key = '0;
        rk_rd_idx = '0; zeroize = 1'b0;
        kv4 = 1'b0; kl4 = 2'b00; ck4 = '0; idx4 = '0; zero4 = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        rst_n = 1'b1;
        #1;

        // Reset values
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_keys_valid", 128'(keys_valid), 128'd0);
        chk("rst_num_rounds", 128'(num_rounds), 128'd0);
        chk("rst_cfg_err", 128'(cfg_err), 128'd0);
        rd("rst_idx0", 4'd0, 128'h0);

        // AES-128, unused LSBs filled with junk
        accept(2'b00, {K128, 128'h0123456789abcdeffedcba9876543210});
        chk("a128_kv_drop", 128'(keys_valid), 128'd0);
        chk("a128_busy", 128'(busy), 128'd1);
        chk("a128_key_ready", 128'(key_ready), 128'd0);
        chk("a128_nr", 128'(num_rounds), 128'd10);
        repeat (39) @(posedge clk_sys);
        #1;
        chk("a128_kv_t39", 128'(keys_valid), 128'd0);
        @(posedge clk_sys);
        #1;
        chk("a128_kv_t40", 128'(keys_valid), 128'd1);
        chk("a128_busy_done", 128'(busy), 128'd0);
        chk("a128_ready", 128'(key_ready), 128'd1);
        rd("a128_idx10", 4'd10, R128_10);
        rd("a128_idx0", 4'd0, K128);
        rd("a128_idx1", 4'd1, R128_1);
        rd("a128_idx11", 4'd11, 128'h0);

        // Reserved key_len in READY
        accept(2'b11, {8{32'h5a5a5a5a}});
        chk("bad_cfg_err", 128'(cfg_err), 128'd1);
        chk("bad_kv", 128'(keys_valid), 128'd1);
        chk("bad_busy", 128'(busy), 128'd0);
        chk("bad_nr", 128'(num_rounds), 128'd10);
        @(posedge clk_sys);
        #1;
        chk("bad_cfg_err_pulse", 128'(cfg_err), 128'd0);
        rd("bad_idx10", 4'd10, R128_10);

        // AES-256 from READY, key_valid held through the first expansion cycles
        @(negedge clk_sys);
        key_valid = 1'b1; key_len = 2'b10; cipher_key = K256;
        @(posedge clk_sys);
        #1;
        chk("a256_kv_drop", 128'(keys_valid), 128'd0);
        chk("a256_busy", 128'(busy), 128'd1);
        key_len = 2'b00; cipher_key = {K128, 128'h0};
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        key_valid = 1'b0;
        repeat (46) @(posedge clk_sys);
        #1;
        chk("a256_kv_t51", 128'(keys_valid), 128'd0);
        @(posedge clk_sys);
        #1;
        chk("a256_kv_t52", 128'(keys_valid), 128'd1);
        chk("a256_nr", 128'(num_rounds), 128'd14);
        rd("a256_idx14", 4'd14, R256_14);
        rd("a256_idx15", 4'd15, 128'h0);
        rd("a256_idx0", 4'd0, R256_0);
        rd("a256_idx1", 4'd1, R256_1);

        // AES-128 over the AES-256 schedule
        accept(2'b00, {K128, {128{1'b1}}});
        chk("r128_kv_drop", 128'(keys_valid), 128'd0);
        repeat (39) @(posedge clk_sys);
        #1;
        chk("r128_kv_t39", 128'(keys_valid), 128'd0);
        @(posedge clk_sys);
        #1;
        chk("r128_kv_t40", 128'(keys_valid), 128'd1);
        chk("r128_nr", 128'(num_rounds), 128'd10);
        rd("r128_idx10", 4'd10, R128_10);
        rd("r128_idx11", 4'd11, 128'h0);
        rd("r128_idx14", 4'd14, 128'h0);

        // AES-192
        accept(2'b01, {K192, 64'hdeadbeefcafef00d});
        chk("a192_nr", 128'(num_rounds), 128'd12);
        repeat (45) @(posedge clk_sys);
        #1;
        chk("a192_kv_t45", 128'(keys_valid), 128'd0);
        @(posedge clk_sys);
        #1;
        chk("a192_kv_t46", 128'(keys_valid), 128'd1);
        rd("a192_idx12", 4'd12, R192_12);
        rd("a192_idx0", 4'd0, R192_0);
        rd("a192_idx13", 4'd13, 128'h0);

        // MAX_NK=4 instance: load AES-128, then reject AES-256
        @(negedge clk_sys);
        kv4 = 1'b1; kl4 = 2'b00; ck4 = K128;
        @(posedge clk_sys);
        #1;
        kv4 = 1'b0;
        chk("n4_nr", 128'(nr4), 128'd10);
        repeat (40) @(posedge clk_sys);
        #1;
        chk("n4_kv", 128'(kvalid4), 128'd1);
        idx4 = 4'd10;
        #1;
        chk("n4_idx10", data4, R128_10);
        @(negedge clk_sys);
        kv4 = 1'b1; kl4 = 2'b10; ck4 = '1;
        @(posedge clk_sys);
        #1;
        kv4 = 1'b0;
        chk("n4_cfg_err", 128'(cerr4), 128'd1);
        chk("n4_kv_kept", 128'(kvalid4), 128'd1);
        chk("n4_nr_kept", 128'(nr4), 128'd10);
        chk("n4_ready", 128'(kr4), 128'd1);
        @(posedge clk_sys);
        #1;
        chk("n4_cfg_err_pulse", 128'(cerr4), 128'd0);
        chk("n4_idx10_kept", data4, R128_10);

        // Reset at cycle 20 of an expansion
        accept(2'b00, {K128, 128'h0});
        repeat (20) @(posedge clk_sys);
        #2;
        chk("mid_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_key_ready", 128'(key_ready), 128'd1);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_kv", 128'(keys_valid), 128'd0);
        chk("mid_rst_nr", 128'(num_rounds), 128'd0);
        chk("mid_rst_cfg_err", 128'(cfg_err), 128'd0);
        rd("mid_rst_idx0", 4'd0, 128'h0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("post_rst_busy", 128'(busy), 128'd0);
        rd("post_rst_idx0", 4'd0, 128'h0);

`ifdef AES_KS_ZEROIZE_EN
        // Zeroize in READY, presented together with a key (zeroize wins)
        accept(2'b00, {K128, 128'h0});
        repeat (40) @(posedge clk_sys);
        #1;
        chk("z_kv_before", 128'(keys_valid), 128'd1);
        @(negedge clk_sys);
        zeroize = 1'b1; key_valid = 1'b1; key_len = 2'b00; cipher_key = {K128, 128'h0};
        @(posedge clk_sys);
        #1;
        zeroize = 1'b0; key_valid = 1'b0;
        chk("z_kv", 128'(keys_valid), 128'd0);
        chk("z_busy", 128'(busy), 128'd0);
        chk("z_key_ready", 128'(key_ready), 128'd1);
        chk("z_nr", 128'(num_rounds), 128'd0);
        chk("z_cfg_err", 128'(cfg_err), 128'd0);
        rd("z_idx0", 4'd0, 128'h0);
        @(posedge clk_sys);
        #1;
        chk("z_no_expand", 128'(busy), 128'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
